// File: rtl/dbg_event_display.sv
// dbg_event_display: debug visibility block for the SoC top.
// Watches N_EVENTS single-bit core status lines, detects edges (any edge or
// rising only), drives a sticky toggle indicator and a saturating counter per
// channel, and scans either a probe word or one counter onto an N_DIGITS
// common-anode seven-segment display.
// Optional build macro DBG_EVENT_DISPLAY_BLANK_EN blanks leading-zero digits.
module dbg_event_display #(
  parameter int N_EVENTS  = 8,
  parameter int CNT_W     = 16,
  parameter int PROBE_W   = 32,
  parameter int N_DIGITS  = 8,
  parameter int SCAN_DIV  = 50000,
  parameter int EDGE_MODE = 0
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [N_EVENTS-1:0] i_event,
  input  logic [PROBE_W-1:0]  i_probe,
  input  logic [4:0]          i_disp_sel,
  input  logic                i_clear,
  output logic [N_EVENTS-1:0] o_toggle,
  output logic [6:0]          o_seg,
  output logic                o_dp,
  output logic [7:0]          o_an
);

  localparam int DISP_W = 4 * N_DIGITS;
  localparam int PRE_W  = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int EXT_W  = PROBE_W + CNT_W + DISP_W;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
  localparam logic [2:0]       IDX_LAST = 3'(N_DIGITS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  // Hex digit to active-low segment pattern {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex7(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      4'hF:    seg = 7'h0E;
      default: seg = 7'h7F;
    endcase
    return seg;
  endfunction

  logic [N_EVENTS-1:0] ev_q_r;
  logic [N_EVENTS-1:0] edge_s;
  logic [N_EVENTS-1:0] toggle_r;
  logic [CNT_W-1:0]    cnt_r [N_EVENTS];

  logic [EXT_W-1:0]  mux_ext_s;
  logic [DISP_W-1:0] mux_s;

  logic [PRE_W-1:0]  pre_r;
  logic [2:0]        idx_r;
  logic              first_r;
  logic [DISP_W-1:0] val_r;
  logic              pre_wrap_s;
  logic              idx_wrap_s;

  logic [DISP_W-1:0] shifted_s;
  logic              blank_s;
  logic [6:0]        seg_s;
  logic              dp_s;
  logic [7:0]        an_s;

  logic [6:0]        seg_r;
  logic              dp_r;
  logic [7:0]        an_r;

  // Edge detector: any edge or rising edge against the one-cycle history.
  always_comb begin
    if (EDGE_MODE == 0) begin
      edge_s = i_event ^ ev_q_r;
    end else begin
      edge_s = i_event & ~ev_q_r;
    end
  end

  // Edge history follows the inputs every cycle, including during clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ev_q_r <= '0;
    end else begin
      ev_q_r <= i_event;
    end
  end

  // Sticky toggle indicators; clear dominates a coincident edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      toggle_r <= '0;
    end else if (i_clear) begin
      toggle_r <= '0;
    end else begin
      toggle_r <= toggle_r ^ edge_s;
    end
  end

  // Saturating per-channel event counters; clear dominates a coincident edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N_EVENTS; i++) cnt_r[i] <= '0;
    end else if (i_clear) begin
      for (int i = 0; i < N_EVENTS; i++) cnt_r[i] <= '0;
    end else begin
      for (int i = 0; i < N_EVENTS; i++) begin
        if (edge_s[i] && (cnt_r[i] != CNT_MAX)) begin
          cnt_r[i] <= cnt_r[i] + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
          cnt_r[i] <= cnt_r[i];
        end
      end
    end
  end

  // Display source mux: probe, one live counter, or zero; fitted to the digit width.
  always_comb begin
    mux_ext_s = '0;
    if (i_disp_sel == 5'd0) begin
      mux_ext_s = EXT_W'(i_probe);
    end else begin
      for (int k = 0; k < N_EVENTS; k++) begin
        mux_ext_s = mux_ext_s |
                    ((i_disp_sel == 5'(k + 1)) ? EXT_W'(cnt_r[k]) : {EXT_W{1'b0}});
      end
    end
    mux_s = mux_ext_s[DISP_W-1:0];
  end

  assign pre_wrap_s = (pre_r == PRE_LAST);
  assign idx_wrap_s = pre_wrap_s && (idx_r == IDX_LAST);

  // Scan prescaler, digit index and frame-latched value (latched only at frame start).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_r   <= '0;
      idx_r   <= 3'd0;
      first_r <= 1'b1;
      val_r   <= '0;
    end else begin
      first_r <= 1'b0;
      if (pre_wrap_s) begin
        pre_r <= '0;
        idx_r <= idx_wrap_s ? 3'd0 : (idx_r + 3'd1);
      end else begin
        pre_r <= pre_r + {{(PRE_W-1){1'b0}}, 1'b1};
        idx_r <= idx_r;
      end
      if (first_r || idx_wrap_s) begin
        val_r <= mux_s;
      end else begin
        val_r <= val_r;
      end
    end
  end

  // Digit decode for the current index from the latched value.
  always_comb begin
    shifted_s = val_r >> {idx_r, 2'b00};
`ifdef DBG_EVENT_DISPLAY_BLANK_EN
    blank_s = (idx_r != 3'd0) && (shifted_s == '0);
`else
    blank_s = 1'b0;
`endif
    an_s = ~(8'd1 << idx_r);
    if (blank_s) begin
      seg_s = 7'h7F;
      dp_s  = 1'b1;
    end else begin
      seg_s = hex7(shifted_s[3:0]);
      dp_s  = ((N_DIGITS == 8) && (idx_r == 3'd4)) ? 1'b0 : 1'b1;
    end
  end

  // Registered display drivers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seg_r <= 7'h7F;
      dp_r  <= 1'b1;
      an_r  <= 8'hFF;
    end else begin
      seg_r <= seg_s;
      dp_r  <= dp_s;
      an_r  <= an_s;
    end
  end

  assign o_toggle = toggle_r;
  assign o_seg    = seg_r;
  assign o_dp     = dp_r;
  assign o_an     = an_r;

endmodule

// File: tb/tb_dbg_event_display.sv
// Randomized scoreboard bench for dbg_event_display with a cycle-count based
// reference model of the event channels and display scan.
module tb_dbg_event_display;

  localparam int NE = 8;
  localparam int CW = 4;
  localparam int PW = 32;
  localparam int ND = 8;
  localparam int SD = 4;
  localparam int EM = 0;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk;
  logic          reset_n;
  logic [NE-1:0] i_event;
  logic [PW-1:0] i_probe;
  logic [4:0]    i_disp_sel;
  logic          i_clear;
  logic [NE-1:0] o_toggle;
  logic [6:0]    o_seg;
  logic          o_dp;
  logic [7:0]    o_an;

  dbg_event_display #(
    .N_EVENTS(NE), .CNT_W(CW), .PROBE_W(PW), .N_DIGITS(ND),
    .SCAN_DIV(SD), .EDGE_MODE(EM)
  ) dut (
    .clk(clk), .reset_n(reset_n), .i_event(i_event), .i_probe(i_probe),
    .i_disp_sel(i_disp_sel), .i_clear(i_clear), .o_toggle(o_toggle),
    .o_seg(o_seg), .o_dp(o_dp), .o_an(o_an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] tog;
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // reference model state
  int         m_p;
  bit [7:0]   m_tog;
  int         m_cnt[NE];
  bit [7:0]   m_prev;
  bit [31:0]  m_lat;
  bit [6:0]   glyph[16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  function automatic bit [31:0] model_mux(input bit [4:0] sel, input bit [31:0] pr);
    if (sel == 5'd0) return pr;
    if (int'(sel) <= NE) return 32'(m_cnt[int'(sel) - 1]);
    return 32'd0;
  endfunction

  function automatic exp_t disp_exp(input int idx, input bit [31:0] lat);
    exp_t e;
    bit [31:0] upper;
    upper = lat >> (4 * idx);
    e.tog = 8'h00;
    e.an  = ~(8'd1 << idx);
    e.seg = glyph[upper[3:0]];
    e.dp  = (ND == 8 && idx == 4) ? 1'b0 : 1'b1;
`ifdef DBG_EVENT_DISPLAY_BLANK_EN
    if (idx != 0 && upper == 32'd0) begin
      e.seg = 7'h7F;
      e.dp  = 1'b1;
    end
`endif
    return e;
  endfunction

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_edge();
    exp_t e;
    bit   ed;
    if (!reset_n) begin
      m_p = 0; m_tog = 8'h00; m_prev = 8'h00; m_lat = 32'd0;
      for (int i = 0; i < NE; i++) m_cnt[i] = 0;
      e.tog = 8'h00; e.an = 8'hFF; e.seg = 7'h7F; e.dp = 1'b1;
      exp_q.push_back(e);
      return;
    end
    m_p++;
    e = disp_exp(((m_p - 1) / SD) % ND, m_lat);
    if (m_p == 1 || (m_p % (SD * ND)) == 0) m_lat = model_mux(i_disp_sel, i_probe);
    for (int i = 0; i < NE; i++) begin
      ed = (EM == 0) ? (i_event[i] != m_prev[i]) : (i_event[i] && !m_prev[i]);
      if (i_clear) begin
        m_tog[i] = 1'b0;
        m_cnt[i] = 0;
      end else if (ed) begin
        m_tog[i] = ~m_tog[i];
        if (m_cnt[i] < CMAX) m_cnt[i] = m_cnt[i] + 1;
      end
    end
    m_prev = i_event;
    e.tog = m_tog;
    exp_q.push_back(e);
  endtask

  task automatic cyc(input bit [7:0] ev, input bit [31:0] pr, input bit [4:0] sel,
                     input bit clr, input bit rn);
    @(negedge clk);
    i_event = ev; i_probe = pr; i_disp_sel = sel; i_clear = clr; reset_n = rn;
    @(posedge clk);
    model_edge();
  endtask

  // Monitor: compares every presented output sample against the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (o_toggle !== e.tog || o_an !== e.an || o_seg !== e.seg || o_dp !== e.dp) begin
          errors++;
          $display("FAIL out t=%0t got tog=%h an=%h seg=%h dp=%b want tog=%h an=%h seg=%h dp=%b",
                   $time, o_toggle, o_an, o_seg, o_dp, e.tog, e.an, e.seg, e.dp);
        end
      end
    end
  end

  initial begin
    bit [7:0]  ev;
    bit [31:0] pr;
    bit [4:0]  sel;
    bit        clr;
    reset_n = 1'b0; i_event = '0; i_probe = '0; i_disp_sel = '0; i_clear = 1'b0;
    ev = 8'h00; pr = 32'h1234ABCD; sel = 5'd0;

    for (int i = 0; i < 3; i++) cyc(ev, pr, sel, 1'b0, 1'b0);
    // full frames of a fixed probe word
    for (int i = 0; i < 3 * ND * SD; i++) cyc(ev, pr, sel, 1'b0, 1'b1);

    // 3-cycle pulse on channel 2, then show counter 2
    sel = 5'd3;
    for (int i = 0; i < 3; i++) cyc(8'h04, pr, sel, 1'b0, 1'b1);
    for (int i = 0; i < 2 * ND * SD; i++) cyc(8'h00, pr, sel, 1'b0, 1'b1);
    ev = 8'h00;

    // saturation on channel 0
    sel = 5'd1;
    for (int i = 0; i < 50; i++) begin
      ev[0] = ~ev[0];
      cyc(ev, pr, sel, 1'b0, 1'b1);
    end
    for (int i = 0; i < 2 * ND * SD; i++) cyc(ev, pr, sel, 1'b0, 1'b1);

    // clear together with an edge on channel 1, later edge
    sel = 5'd2;
    ev[1] = ~ev[1];
    cyc(ev, pr, sel, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) cyc(ev, pr, sel, 1'b0, 1'b1);
    ev[1] = ~ev[1];
    for (int i = 0; i < 2 * ND * SD; i++) cyc(ev, pr, sel, 1'b0, 1'b1);

    // randomized traffic with one mid-scan reset
    for (int i = 0; i < 2500; i++) begin
      for (int b = 0; b < NE; b++) if ($urandom_range(3) == 0) ev[b] = ~ev[b];
      if ($urandom_range(19) == 0) pr = ($urandom_range(1) == 0) ? $urandom : $urandom_range(255);
      if ($urandom_range(39) == 0) sel = 5'($urandom_range(31));
      else if ($urandom_range(59) == 0) sel = 5'($urandom_range(NE));
      clr = ($urandom_range(49) == 0);
      cyc(ev, pr, sel, clr, (i >= 1203 && i < 1206) ? 1'b0 : 1'b1);
    end

    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
